// File: rtl/pulse_burst_ctrl_pkg.sv
// Shared definitions for the pulse burst controller: FSM encoding,
// default field widths and small helpers.
package pulse_burst_ctrl_pkg;

  localparam int CW_DEF = 4;
  localparam int NW_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2,
    ST_END  = 2'd3
  } state_e;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/pulse_burst_ctrl_timer.sv
// Loadable phase down-counter; zero flags the last cycle of the current phase.
module pulse_burst_ctrl_timer #(
  parameter int CW = 4
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          load,
  input  logic [CW-1:0] value,
  output logic          zero
);

  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/pulse_burst_ctrl.sv
// Round-robin scheduler sharing one pulse-train output between two requesters.
//
//   state | meaning
//   IDLE  | no owner; arbitrate on req each cycle
//   HIGH  | signal high, timer counts the high phase
//   LOW   | signal low, timer counts the low phase, then next pulse or END
//   END   | one-cycle done pulse to the owner, busy still high
module pulse_burst_ctrl
  import pulse_burst_ctrl_pkg::*;
#(
  parameter int CW = CW_DEF,
  parameter int NW = NW_DEF
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [1:0]      req,
  input  logic [2*CW-1:0] high_w,
  input  logic [2*CW-1:0] low_w,
  input  logic [2*NW-1:0] count,
  output logic [1:0]      ack,
  output logic [1:0]      done,
  output logic            signal,
  output logic            busy,
  output logic            owner
);

  localparam logic [CW-1:0] CW_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [NW-1:0] NW_ONE = {{(NW-1){1'b0}}, 1'b1};

  state_e        state_q, state_d;
  logic [1:0]    ack_q, ack_d;
  logic          owner_q, owner_d;
  logic          ptr_q, ptr_d;
  logic [CW-1:0] hw_q, hw_d;
  logic [CW-1:0] lw_q, lw_d;
  logic [NW-1:0] pulses_q, pulses_d;

  logic          win;
  logic [CW-1:0] sel_hw, sel_lw;
  logic [NW-1:0] sel_cnt;
  logic          tmr_load;
  logic [CW-1:0] tmr_value;
  logic          tmr_zero;

  // A zero width behaves as one cycle, so the timer reload is width-1 floored at 0.
  function automatic logic [CW-1:0] phase_load(input logic [CW-1:0] w);
    return (w == '0) ? '0 : (w - CW_ONE);
  endfunction

  assign win     = (req == 2'b11) ? ~ptr_q : req[1];
  assign sel_hw  = win ? high_w[2*CW-1:CW] : high_w[CW-1:0];
  assign sel_lw  = win ? low_w[2*CW-1:CW]  : low_w[CW-1:0];
  assign sel_cnt = win ? count[2*NW-1:NW]  : count[NW-1:0];

  pulse_burst_ctrl_timer #(.CW(CW)) u_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (tmr_load),
    .value   (tmr_value),
    .zero    (tmr_zero)
  );

  // Pointer resets to 1 so that a simultaneous first request goes to requester 0.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      ack_q    <= 2'b00;
      owner_q  <= 1'b0;
      ptr_q    <= 1'b1;
      hw_q     <= '0;
      lw_q     <= '0;
      pulses_q <= '0;
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      hw_q     <= hw_d;
      lw_q     <= lw_d;
      pulses_q <= pulses_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ack_d     = 2'b00;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    hw_d      = hw_q;
    lw_d      = lw_q;
    pulses_d  = pulses_q;
    tmr_load  = 1'b0;
    tmr_value = '0;
    case (state_q)
      ST_IDLE: begin
        if (req != 2'b00) begin
          ack_d    = onehot2(win);
          owner_d  = win;
          ptr_d    = win;
          hw_d     = sel_hw;
          lw_d     = sel_lw;
          pulses_d = sel_cnt;
          if (sel_cnt != '0) begin
            state_d   = ST_HIGH;
            tmr_load  = 1'b1;
            tmr_value = phase_load(sel_hw);
          end else begin
            state_d = ST_END;
          end
        end
      end
      ST_HIGH: begin
        if (tmr_zero) begin
          state_d   = ST_LOW;
          tmr_load  = 1'b1;
          tmr_value = phase_load(lw_q);
        end
      end
      ST_LOW: begin
        if (tmr_zero) begin
          if (pulses_q == NW_ONE) begin
            state_d = ST_END;
          end else begin
            pulses_d  = pulses_q - NW_ONE;
            state_d   = ST_HIGH;
            tmr_load  = 1'b1;
            tmr_value = phase_load(hw_q);
          end
        end
      end
      ST_END: begin
        // A zero-count grant lands here with ack still showing; hold one more
        // cycle so done follows ack instead of coinciding with it.
        if (ack_q == 2'b00) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    signal = (state_q == ST_HIGH);
    busy   = (state_q != ST_IDLE);
    ack    = ack_q;
    owner  = owner_q;
    done   = 2'b00;
    if ((state_q == ST_END) && (ack_q == 2'b00)) begin
      done = onehot2(owner_q);
    end
  end

endmodule

// File: tb/tb_pulse_burst_ctrl.sv
// Self-checking bench for pulse_burst_ctrl: directed vector table, hand-written
// corner sequences and randomized traffic against a burst-expansion model.
module tb_pulse_burst_ctrl;

  logic       clock;
  logic       reset_n;
  logic [1:0] req;
  logic [7:0] high_w;
  logic [7:0] low_w;
  logic [5:0] count;
  logic [1:0] ack;
  logic [1:0] done;
  logic       signal;
  logic       busy;
  logic       owner;

  int checks   = 0;
  int failures = 0;

  pulse_burst_ctrl #(.CW(4), .NW(3)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .req     (req),
    .high_w  (high_w),
    .low_w   (low_w),
    .count   (count),
    .ack     (ack),
    .done    (done),
    .signal  (signal),
    .busy    (busy),
    .owner   (owner)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic       sig;
    logic       bsy;
    logic [1:0] ak;
    logic [1:0] dn;
    logic       own;
  } obs_t;

  typedef struct {
    logic [1:0] rq;
    logic [3:0] hw0, lw0;
    logic [2:0] c0;
    logic [3:0] hw1, lw1;
    logic [2:0] c1;
    logic       own;
    int         blen;
    int         hcnt;
  } vec_t;

  vec_t tbl[7];

  obs_t q[$];
  logic m_ptr;
  logic m_owner;

  function automatic logic [1:0] oh(input logic i);
    return i ? 2'b10 : 2'b01;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Expand a granted burst into its expected per-cycle observations.
  task automatic model_grant();
    logic w;
    int h, l, c;
    logic [1:0] a;
    w = (req == 2'b11) ? ~m_ptr : req[1];
    m_ptr   = w;
    m_owner = w;
    h = w ? int'(high_w[7:4]) : int'(high_w[3:0]);
    l = w ? int'(low_w[7:4])  : int'(low_w[3:0]);
    c = w ? int'(count[5:3])  : int'(count[2:0]);
    if (h == 0) h = 1;
    if (l == 0) l = 1;
    a = oh(w);
    if (c == 0) begin
      q.push_back({1'b0, 1'b1, a, 2'b00, w});
      q.push_back({1'b0, 1'b1, 2'b00, a, w});
    end else begin
      for (int p = 0; p < c; p++) begin
        for (int k = 0; k < h; k++)
          q.push_back({1'b1, 1'b1, ((p == 0) && (k == 0)) ? a : 2'b00, 2'b00, w});
        for (int k = 0; k < l; k++)
          q.push_back({1'b0, 1'b1, 2'b00, 2'b00, w});
      end
      q.push_back({1'b0, 1'b1, 2'b00, a, w});
    end
  endtask

  // Called during an IDLE cycle; applies r/cfg, then the *2 values after grant.
  task automatic run_burst(input logic [1:0] r, input logic [7:0] hw, input logic [7:0] lw,
                           input logic [5:0] c, input logic [1:0] r2, input logic [7:0] hw2,
                           input logic [7:0] lw2, input logic [5:0] c2,
                           output int blen, output int hcnt, output int acks,
                           output int dones, output int bad, output logic own);
    int guard;
    blen = 0; hcnt = 0; acks = 0; dones = 0; bad = 0; guard = 0;
    req = r; high_w = hw; low_w = lw; count = c;
    @(posedge clock); #1;
    own = owner;
    req = r2; high_w = hw2; low_w = lw2; count = c2;
    while (busy && guard < 400) begin
      blen++;
      if (signal) hcnt++;
      if (ack == oh(own)) acks++; else if (ack != 2'b00) bad++;
      if (done == oh(own)) dones++; else if (done != 2'b00) bad++;
      if ((ack != 2'b00) && (done != 2'b00)) bad++;
      @(posedge clock); #1;
      guard++;
    end
    if (guard >= 400) check("burst_timeout", guard, 0);
  endtask

  initial begin
    int blen, hcnt, acks, dones, bad;
    logic own;
    logic sig_h[24];
    logic [1:0] ack_h[24], done_h[24];
    int d1, a2, r2, lasth, busy_cnt, done_cnt, guard;
    logic cur_idle;
    obs_t exp_o;

    tbl[0] = '{2'b01, 4'd3, 4'd3, 3'd4, 4'd0, 4'd0, 3'd0, 1'b0, 25, 12};
    tbl[1] = '{2'b11, 4'd2, 4'd1, 3'd1, 4'd1, 4'd2, 3'd2, 1'b1, 7, 2};
    tbl[2] = '{2'b11, 4'd2, 4'd1, 3'd1, 4'd1, 4'd2, 3'd2, 1'b0, 4, 2};
    tbl[3] = '{2'b11, 4'd2, 4'd1, 3'd1, 4'd1, 4'd2, 3'd2, 1'b1, 7, 2};
    tbl[4] = '{2'b01, 4'd5, 4'd5, 3'd0, 4'd0, 4'd0, 3'd0, 1'b0, 2, 0};
    tbl[5] = '{2'b10, 4'd7, 4'd7, 3'd3, 4'd0, 4'd0, 3'd2, 1'b1, 5, 2};
    tbl[6] = '{2'b10, 4'd1, 4'd1, 3'd1, 4'd15, 4'd15, 3'd7, 1'b1, 211, 105};

    reset_n = 1'b0; req = 2'b00; high_w = '0; low_w = '0; count = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_signal", int'(signal), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ack", int'(ack), 0);
    check("rst_done", int'(done), 0);
    check("rst_owner", int'(owner), 0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < 7; i++) begin
      run_burst(tbl[i].rq, {tbl[i].hw1, tbl[i].hw0}, {tbl[i].lw1, tbl[i].lw0},
                {tbl[i].c1, tbl[i].c0}, 2'b00, {tbl[i].hw1, tbl[i].hw0},
                {tbl[i].lw1, tbl[i].lw0}, {tbl[i].c1, tbl[i].c0},
                blen, hcnt, acks, dones, bad, own);
      check($sformatf("vec%0d_owner", i), int'(own), int'(tbl[i].own));
      check($sformatf("vec%0d_busy_len", i), blen, tbl[i].blen);
      check($sformatf("vec%0d_high_cycles", i), hcnt, tbl[i].hcnt);
      check($sformatf("vec%0d_ack_pulses", i), acks, 1);
      check($sformatf("vec%0d_done_pulses", i), dones, 1);
      check($sformatf("vec%0d_stray_ack_done", i), bad, 0);
    end

    // Configuration changed right after grant: current burst keeps old values.
    run_burst(2'b01, 8'h02, 8'h02, 6'd3, 2'b01, 8'h05, 8'h05, 6'd3,
              blen, hcnt, acks, dones, bad, own);
    check("cfgchg_first_busy_len", blen, 13);
    check("cfgchg_first_high", hcnt, 6);
    run_burst(2'b01, 8'h05, 8'h05, 6'd3, 2'b00, 8'h05, 8'h05, 6'd3,
              blen, hcnt, acks, dones, bad, own);
    check("cfgchg_second_busy_len", blen, 31);
    check("cfgchg_second_high", hcnt, 15);

    // req0 held: regrant after exactly one IDLE cycle.
    req = 2'b01; high_w = 8'h02; low_w = 8'h01; count = 6'd1;
    for (int i = 0; i < 24; i++) begin
      @(posedge clock); #1;
      sig_h[i] = signal; ack_h[i] = ack; done_h[i] = done;
    end
    d1 = -1; a2 = -1; r2 = -1; lasth = -1;
    for (int i = 0; i < 24; i++) begin
      if (done_h[i] == 2'b01 && d1 < 0) d1 = i;
      if (ack_h[i] == 2'b01 && i > 0 && d1 >= 0 && a2 < 0) a2 = i;
      if (sig_h[i] && i > 0 && !sig_h[i-1] && r2 < 0) r2 = i;
      if (sig_h[i] && r2 < 0) lasth = i;
    end
    check("held_first_done_idx", d1, 3);
    check("held_regrant_gap", a2 - d1, 2);
    check("held_low_between", r2 - lasth - 1, 3);
    req = 2'b00;
    guard = 0;
    while (busy && guard < 300) begin
      @(posedge clock); #1;
      guard++;
    end
    check("held_drain", int'(busy), 0);

    // Asynchronous reset in the middle of a requester-1 high phase.
    req = 2'b10; high_w = 8'h30; low_w = 8'h30; count = 6'o40;
    @(posedge clock); #1;
    check("abort_grant_owner", int'(owner), 1);
    req = 2'b00;
    @(posedge clock);
    @(posedge clock);
    #3;
    check("abort_pre_signal", int'(signal), 1);
    reset_n = 1'b0;
    #1;
    check("abort_signal", int'(signal), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_ack", int'(ack), 0);
    check("abort_done", int'(done), 0);
    check("abort_owner", int'(owner), 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clock); #1;
      if (busy) busy_cnt++;
      if (done != 2'b00) done_cnt++;
    end
    check("abort_no_done", done_cnt, 0);
    check("abort_no_busy", busy_cnt, 0);

    // Randomized traffic against the burst-expansion model.
    reset_n = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    q.delete();
    m_ptr = 1'b1; m_owner = 1'b0; cur_idle = 1'b1;
    req = 2'($urandom_range(0, 3));
    high_w = 8'($urandom); low_w = 8'($urandom); count = 6'($urandom);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clock);
      if (cur_idle && req != 2'b00) model_grant();
      #1;
      if (q.size() > 0) begin
        exp_o = q.pop_front();
        cur_idle = 1'b0;
      end else begin
        exp_o = {1'b0, 1'b0, 2'b00, 2'b00, m_owner};
        cur_idle = 1'b1;
      end
      check($sformatf("rand_cycle%0d_obs", cyc), int'({signal, busy, ack, done, owner}),
            int'(exp_o));
      if ($urandom_range(0, 3) == 0) req = 2'($urandom_range(0, 3));
      high_w = 8'($urandom); low_w = 8'($urandom); count = 6'($urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
